// File: rtl/scroll_msg_sequencer_if.sv
// Requester handshakes and display/status outputs of scroll_msg_sequencer.
// master : requesters and display side (drive req*_valid/data/last, observe the rest)
// slave  : the sequencer (drives ready, display bus and status)
interface scroll_msg_sequencer_if;
  logic       req0_valid;
  logic [6:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [6:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       disp_clk;
  logic [6:0] disp_din;
  logic       busy;
  logic [1:0] grant;
  logic       trunc;
  logic       subst;

  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
    input  req0_ready, req1_ready, disp_clk, disp_din, busy, grant, trunc, subst
  );

  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
    output req0_ready, req1_ready, disp_clk, disp_din, busy, grant, trunc, subst
  );
endinterface

// File: rtl/scroll_msg_sequencer.sv
// Arbitrates two message requesters and streams the granted message into the
// scrolling display, one character per generated display-clock pulse, padded
// or truncated to WORD_COUNT characters, then holds the run code for
// SHOW_STEPS display clocks.
// Ports: clk, rst_n (async, active low), bus (slave modport: requester
// handshakes, disp_clk/disp_din, busy, grant, trunc, subst).
//
// state | meaning
// IDLE  | display clock parked low, bus at run code, waiting for a request
// LOAD  | one display step per slot; stalls on missing data, drops overflow
// SHOW  | run code held for SHOW_STEPS display clocks
module scroll_msg_sequencer #(
  parameter int WORD_COUNT = 20,
  parameter int HALF       = 2,
  parameter int SHOW_STEPS = 320
) (
  input logic                   clk,
  input logic                   rst_n,
  scroll_msg_sequencer_if.slave bus
);
  localparam int STEP   = 2 * HALF;
  localparam int PH_W   = $clog2(STEP);
  localparam int SLOT_W = $clog2(WORD_COUNT + 1);
  localparam int SH_W   = $clog2(SHOW_STEPS + 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(STEP - 1);
  localparam logic [PH_W-1:0]   PH_RISE   = PH_W'(HALF);
  localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(WORD_COUNT);
  localparam logic [SH_W-1:0]   SHOW_LAST = SH_W'(SHOW_STEPS - 1);
  localparam logic [6:0]        RUN       = 7'h7F;
  localparam logic [6:0]        PAD       = 7'h40;

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [SH_W-1:0]   show_q, show_d;
  logic              act_q, act_d;      // a display step is running
  logic              ended_q, ended_d;  // last already consumed
  logic              owner_q, owner_d;  // 0: requester 0 granted
  logic              pri_q, pri_d;      // requester favoured on a tie
  logic [6:0]        din_q, din_d;
  logic              dclk_q, dclk_d;
  logic              trunc_q, trunc_d;
  logic              subst_q, subst_d;

  logic       free;
  logic       take;
  logic       cur_valid;
  logic [6:0] cur_data;
  logic       cur_last;

  assign cur_valid = owner_q ? bus.req1_valid : bus.req0_valid;
  assign cur_data  = owner_q ? bus.req1_data  : bus.req0_data;
  assign cur_last  = owner_q ? bus.req1_last  : bus.req0_last;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    ph_d    = ph_q;
    show_d  = show_q;
    act_d   = act_q;
    ended_d = ended_q;
    owner_d = owner_q;
    pri_d   = pri_q;
    din_d   = din_q;
    trunc_d = 1'b0;
    subst_d = 1'b0;
    take    = 1'b0;
    // A new step (or a stall decision) is only taken once the current step
    // has spent its last cycle, so disp_din never moves mid-step.
    free    = !act_q || (ph_q == PH_LAST);
    if (act_q && ph_q != PH_LAST) ph_d = ph_q + 1'b1;

    case (state_q)
      IDLE: begin
        act_d = 1'b0;
        din_d = RUN;
        if (bus.req0_valid || bus.req1_valid) begin
          state_d = LOAD;
          slot_d  = '0;
          ph_d    = '0;
          ended_d = 1'b0;
          owner_d = (bus.req0_valid && bus.req1_valid) ? pri_q : bus.req1_valid;
          pri_d   = ~owner_d;
        end
      end
      LOAD: begin
        if (free) begin
          act_d = 1'b0;
          ph_d  = '0;
          if (slot_q != SLOT_FULL) begin
            if (ended_q) begin
              din_d  = PAD;
              slot_d = slot_q + 1'b1;
              act_d  = 1'b1;
            end else if (cur_valid) begin
              take    = 1'b1;
              subst_d = (cur_data == RUN);
              din_d   = (cur_data == RUN) ? PAD : cur_data;
              ended_d = cur_last;
              slot_d  = slot_q + 1'b1;
              act_d   = 1'b1;
            end
          end else if (ended_q) begin
            state_d = SHOW;
            din_d   = RUN;
            show_d  = SHOW_LAST;
            act_d   = 1'b1;
          end else if (cur_valid) begin
            // overflow characters are swallowed one per cycle, no step
            take    = 1'b1;
            trunc_d = 1'b1;
            ended_d = cur_last;
          end
        end
      end
      SHOW: begin
        if (free) begin
          ph_d = '0;
          if (show_q == '0) begin
            state_d = IDLE;
            act_d   = 1'b0;
          end else begin
            show_d = show_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    dclk_d = act_d && (ph_d >= PH_RISE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      ph_q    <= '0;
      show_q  <= '0;
      act_q   <= 1'b0;
      ended_q <= 1'b0;
      owner_q <= 1'b0;
      pri_q   <= 1'b0;
      din_q   <= RUN;
      dclk_q  <= 1'b0;
      trunc_q <= 1'b0;
      subst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ph_q    <= ph_d;
      show_q  <= show_d;
      act_q   <= act_d;
      ended_q <= ended_d;
      owner_q <= owner_d;
      pri_q   <= pri_d;
      din_q   <= din_d;
      dclk_q  <= dclk_d;
      trunc_q <= trunc_d;
      subst_q <= subst_d;
    end
  end

  assign bus.req0_ready = take & ~owner_q;
  assign bus.req1_ready = take &  owner_q;
  assign bus.disp_clk   = dclk_q;
  assign bus.disp_din   = din_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant      = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign bus.trunc      = trunc_q;
  assign bus.subst      = subst_q;
endmodule

// File: tb/tb_scroll_msg_sequencer.sv
// Bench for scroll_msg_sequencer: two requester feeders, an output monitor
// and a message-level reference model (expected display edge stream, grant
// order, pulse and handshake counts).
module tb_scroll_msg_sequencer;
  localparam int WORD_COUNT = 20;
  localparam int HALF       = 2;
  localparam int SHOW_STEPS = 320;
  localparam logic [6:0] RUN = 7'h7F;
  localparam logic [6:0] PAD = 7'h40;

  typedef struct {
    logic [6:0] d;
    logic       l;
    int         gap;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  scroll_msg_sequencer_if bus();

  scroll_msg_sequencer #(
    .WORD_COUNT(WORD_COUNT),
    .HALF      (HALF),
    .SHOW_STEPS(SHOW_STEPS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  item_t      q0[$], q1[$], msg0[$], msg1[$];
  int         pend0 = 0, pend1 = 0;
  logic [6:0] exp_edges[$], got_edges[$];
  logic [1:0] exp_grants[$], got_grants[$];
  int exp_tr = 0, exp_su = 0, exp_r0 = 0, exp_r1 = 0;
  int got_tr = 0, got_su = 0, got_r0 = 0, got_r1 = 0;
  int pri = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] shown(input logic [6:0] c);
    return (c == RUN) ? PAD : c;
  endfunction

  task automatic drive(input int id, input logic v, input logic [6:0] d, input logic l);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
    end
  endtask

  // output monitor, sampled mid-cycle
  logic prev_dclk = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dclk = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (bus.disp_clk && !prev_dclk) begin
        got_edges.push_back(bus.disp_din);
        chk("edge_busy", bus.busy, 1);
      end
      if (bus.busy && !prev_busy) got_grants.push_back(bus.grant);
      if (bus.trunc) got_tr++;
      if (bus.subst) got_su++;
      if (bus.req0_ready) begin got_r0++; chk("rdy0_grant", bus.grant, 2'b01); end
      if (bus.req1_ready) begin got_r1++; chk("rdy1_grant", bus.grant, 2'b10); end
      prev_dclk = bus.disp_clk;
      prev_busy = bus.busy;
    end
  end

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic item_t qpop(input int id);
    if (id == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic run_feeder(input int id);
    item_t      it;
    int         idx;
    int         n;
    logic [6:0] prev;
    logic       seen;
    idx  = 0;
    prev = RUN;
    forever begin
      while (qsize(id) == 0) begin @(posedge clk); #1; end
      it = qpop(id);
      for (int k = 0; k < it.gap; k++) begin
        @(negedge clk);
        // long mid-message gap: display must freeze once the step ends
        if (it.gap >= 8 && idx > 0 && idx < WORD_COUNT) begin
          chk("stall_din", bus.disp_din, prev);
          if (k >= 2 * HALF) chk("stall_dclk", bus.disp_clk, 0);
        end
        @(posedge clk); #1;
      end
      drive(id, 1'b1, it.d, it.l);
      n = 0;
      do begin
        @(negedge clk);
        seen = (id == 0) ? bus.req0_ready : bus.req1_ready;
        n++;
      end while (!seen && n < 20000);
      if (!seen) begin
        if (id == 0) chk("hs_timeout0", seen, 1);
        else         chk("hs_timeout1", seen, 1);
      end
      @(posedge clk); #1;
      drive(id, 1'b0, 7'h00, 1'b0);
      prev = shown(it.d);
      idx  = it.l ? 0 : idx + 1;
      if (id == 0) pend0--; else pend1--;
    end
  endtask

  initial run_feeder(0);
  initial run_feeder(1);

  task automatic add_char(input int id, input logic [6:0] d, input logic l, input int gap);
    item_t x;
    x.d = d; x.l = l; x.gap = gap;
    if (id == 0) msg0.push_back(x); else msg1.push_back(x);
  endtask

  // reference model: what the display must see for one whole message
  task automatic expect_msg(input int id);
    item_t m[$];
    if (id == 0) m = msg0; else m = msg1;
    exp_grants.push_back((id == 0) ? 2'b01 : 2'b10);
    for (int s = 0; s < WORD_COUNT; s++)
      exp_edges.push_back((s < m.size()) ? shown(m[s].d) : PAD);
    for (int s = 0; s < SHOW_STEPS; s++) exp_edges.push_back(RUN);
    for (int s = 0; s < m.size() && s < WORD_COUNT; s++)
      if (m[s].d == RUN) exp_su++;
    if (m.size() > WORD_COUNT) exp_tr += m.size() - WORD_COUNT;
    if (id == 0) exp_r0 += m.size(); else exp_r1 += m.size();
  endtask

  task automatic launch();
    if (msg0.size() > 0 && msg1.size() > 0) begin
      expect_msg(pri);
      expect_msg(1 - pri);
    end else if (msg0.size() > 0) begin
      expect_msg(0);
      pri = 1;
    end else begin
      expect_msg(1);
      pri = 0;
    end
    pend0 += msg0.size();
    pend1 += msg1.size();
    foreach (msg0[i]) q0.push_back(msg0[i]);
    foreach (msg1[i]) q1.push_back(msg1[i]);
    msg0.delete();
    msg1.delete();
  endtask

  task automatic compare_all();
    int e0;
    chk("edge_count", got_edges.size(), exp_edges.size());
    for (int i = 0; i < exp_edges.size() && i < got_edges.size(); i++) begin
      e0 = n_err;
      chk("edge_din", got_edges[i], exp_edges[i]);
      if (n_err != e0) break;
    end
    chk("grant_count", got_grants.size(), exp_grants.size());
    for (int i = 0; i < exp_grants.size() && i < got_grants.size(); i++)
      chk("grant_order", got_grants[i], exp_grants[i]);
    chk("trunc_pulses", got_tr, exp_tr);
    chk("subst_pulses", got_su, exp_su);
    chk("ready0_count", got_r0, exp_r0);
    chk("ready1_count", got_r1, exp_r1);
    exp_edges.delete(); got_edges.delete();
    exp_grants.delete(); got_grants.delete();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pend0 == 0 && pend1 == 0 && !bus.busy) && n < 20000);
    chk("idle_busy", bus.busy, 0);
    chk("idle_pending", pend0 + pend1, 0);
    chk("idle_dclk", bus.disp_clk, 0);
    chk("idle_din", bus.disp_din, RUN);
    compare_all();
  endtask

  task automatic build(input int id, input int len);
    int r;
    for (int i = 0; i < len; i++) begin
      logic [6:0] d;
      int         g;
      d = ($urandom_range(0, 7) == 0) ? RUN : 7'($urandom_range(0, 127));
      r = $urandom_range(0, 19);
      if (i == 0)      g = 0;
      else if (r < 15) g = 0;
      else if (r < 19) g = $urandom_range(1, 2);
      else             g = $urandom_range(10, 12);
      add_char(id, d, (i == len - 1), g);
    end
  endtask

  initial begin
    int n;
    drive(0, 1'b0, 7'h00, 1'b0);
    drive(1, 1'b0, 7'h00, 1'b0);
    #1;
    // reset state, with a requester already valid
    bus.req0_valid = 1'b1;
    #20;
    chk("rst_dclk", bus.disp_clk, 0);
    chk("rst_din", bus.disp_din, RUN);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_rdy0", bus.req0_ready, 0);
    chk("rst_rdy1", bus.req1_ready, 0);
    chk("rst_trunc", bus.trunc, 0);
    chk("rst_subst", bus.subst, 0);
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_dclk", bus.disp_clk, 0);

    // both requesters valid after reset: 0 first, then 1
    add_char(0, 7'h31, 0, 0); add_char(0, 7'h32, 0, 0); add_char(0, 7'h33, 1, 0);
    add_char(1, 7'h41, 0, 0); add_char(1, 7'h42, 1, 0);
    launch(); wait_done();

    // single character, then 19 pads
    add_char(0, 7'h60, 1, 0);
    launch(); wait_done();

    // 10-cycle hole mid-message
    for (int i = 0; i < 8; i++) add_char(0, 7'(8'h50 + i), (i == 7), (i == 4) ? 10 : 0);
    launch(); wait_done();

    // 23 characters: three dropped
    for (int i = 0; i < 23; i++) add_char(0, 7'(8'h10 + i), (i == 22), 0);
    launch(); wait_done();

    // run code inside the message at slot 5
    for (int i = 0; i < 9; i++) add_char(1, (i == 5) ? RUN : 7'(8'h20 + i), (i == 8), 0);
    launch(); wait_done();

    for (int it = 0; it < 12; it++) begin
      int mask;
      mask = $urandom_range(1, 3);
      if (mask[0]) build(0, $urandom_range(1, 25));
      if (mask[1]) build(1, $urandom_range(1, 25));
      launch(); wait_done();
    end

    // reset in the middle of SHOW step 100
    add_char(0, 7'h21, 1, 0);
    launch();
    n = 0;
    while (got_edges.size() < WORD_COUNT + 100 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("show100_reached", got_edges.size(), WORD_COUNT + 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dclk", bus.disp_clk, 0);
    chk("mid_rst_din", bus.disp_din, RUN);
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_busy", bus.busy, 0);
    exp_edges.delete(); got_edges.delete();
    exp_grants.delete(); got_grants.delete();
    pri = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_char(1, 7'h55, 1, 0);
    add_char(0, 7'h66, 0, 0); add_char(0, 7'h67, 1, 0);
    launch(); wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
